// File: rtl/spi_cmd_sequencer.sv
// Command sequencer feeding an SPI master: buffers TX words in a FIFO, launches one
// master transfer per word via send/busy, captures the reply and watches for a stuck master.
module spi_cmd_sequencer #(
  parameter int unsigned BITS    = 28,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [BITS-1:0]          i_wr_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [BITS-1:0]          o_rx_data,
  output logic                     o_rx_valid,
  output logic                     o_err_timeout,
  output logic                     o_idle,
  output logic [BITS-1:0]          o_m_data,
  output logic                     o_m_send,
  input  logic                     i_m_busy,
  input  logic [BITS-1:0]          i_m_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] PtrOne  = 1;
  localparam logic [AW:0]   LvlOne  = 1;
  localparam logic [AW:0]   LvlFull = DEPTH;
  localparam logic [WW-1:0] WdogOne = 1;
  localparam logic [WW-1:0] WdogMax = TIMEOUT;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StCapture
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_level;
  logic [WW-1:0]   r_wdog, w_wdog_nxt;
  logic [BITS-1:0] r_m_data, r_rx_data;
  logic            r_rx_valid;
  logic            w_push, w_pop, w_start, w_timeout;

  assign o_wr_ready = (r_level != LvlFull);
  assign w_push     = i_wr_valid & o_wr_ready;
  assign w_pop      = (r_state == StLaunch);
  assign w_start    = (r_state == StIdle) && (r_level != '0) && !i_m_busy;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LvlOne;
        2'b01:   r_level <= r_level - LvlOne;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_timeout   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_nxt = StLaunch;
      end
      StLaunch: begin
        w_wdog_nxt  = '0;
        w_state_nxt = StWaitBusy;
      end
      StWaitBusy: begin
        if (i_m_busy) begin
          w_state_nxt = StWaitDone;
        end else if (r_wdog == WdogMax) begin
          // Master never picked the word up: drop it and report.
          w_timeout   = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_wdog_nxt = r_wdog + WdogOne;
        end
      end
      StWaitDone: begin
        if (!i_m_busy) w_state_nxt = StCapture;
      end
      StCapture: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_wdog     <= '0;
      r_m_data   <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wdog     <= w_wdog_nxt;
      r_rx_valid <= (r_state == StCapture);
      // Load the head on entry to LAUNCH so the word is valid while send is high.
      if (w_start) r_m_data <= r_mem[r_rptr];
      if (r_state == StCapture) r_rx_data <= i_m_data;
    end
  end

  assign o_level       = r_level;
  assign o_m_data      = r_m_data;
  assign o_m_send      = (r_state == StLaunch);
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_err_timeout = w_timeout;
  assign o_idle        = (r_state == StIdle) && (r_level == '0);

endmodule
